// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stage controller.
package pipe_ctrl_pkg;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned FCNT_W           = 4;   // holds FLUSH_CYCLES up to 15
    localparam int unsigned REG_W            = 5;   // register specifier width

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/execute/memory status in, stage enables and perf counters out.
interface pipeline_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rd_memory;
    logic             ex_save_to_reg;
    logic             ex_mispredict;
    logic             mem_busy;
    logic             clr_cnt;

    logic             if_ena;
    logic             id_ena;
    logic             id_x;
    logic             ex_x;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_rd_memory, ex_save_to_reg, ex_mispredict, mem_busy, clr_cnt,
        input  if_ena, id_ena, id_x, ex_x, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_rd_memory, ex_save_to_reg, ex_mispredict, mem_busy, clr_cnt,
        output if_ena, id_ena, id_x, ex_x, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: decode reads a register that the load in execute writes.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_rd_memory_i,
    input  logic             ex_save_to_reg_i,
    output logic             load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_rd_memory_i && ex_save_to_reg_i &&
                        (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage controller: load-use stalls, redirect flushes, memory waits,
// plus saturating stall/flush performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic           stg_clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);

    logic             load_use;
    state_e           state_q, state_d;
    state_e           saved_q, saved_d;
    state_e           eff;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             if_ena, id_ena, id_x, ex_x;
    logic             accept;

    hazard_detect u_hazard (
        .id_rs1_i         (bus.id_rs1),
        .id_rs2_i         (bus.id_rs2),
        .id_rs1_used_i    (bus.id_rs1_used),
        .id_rs2_used_i    (bus.id_rs2_used),
        .ex_rd_i          (bus.ex_rd),
        .ex_rd_memory_i   (bus.ex_rd_memory),
        .ex_save_to_reg_i (bus.ex_save_to_reg),
        .load_use_o       (load_use)
    );

    // Next state and stage controls; the mem_busy-falling cycle of MEM_WAIT
    // is evaluated as the saved state so resumption costs no extra cycle.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        if_ena  = 1'b0;
        id_ena  = 1'b0;
        id_x    = 1'b0;
        ex_x    = 1'b0;
        accept  = 1'b0;
        eff     = state_q;
        if (state_q == ST_MEM_WAIT) begin
            eff = saved_q;
        end

        if (reset) begin
            id_x = 1'b1;
            ex_x = 1'b1;
        end else if ((state_q == ST_MEM_WAIT) && bus.mem_busy) begin
            pend_d = pend_q | bus.ex_mispredict;
        end else if (bus.ex_mispredict || pend_q) begin
            if_ena  = 1'b1;
            id_ena  = 1'b1;
            id_x    = 1'b1;
            ex_x    = 1'b1;
            accept  = 1'b1;
            pend_d  = 1'b0;
            fcnt_d  = FLUSH_LOAD;
            state_d = ST_FLUSH;
        end else if (bus.mem_busy) begin
            saved_d = eff;
            state_d = ST_MEM_WAIT;
        end else if (eff == ST_FLUSH) begin
            if_ena  = 1'b1;
            id_ena  = 1'b1;
            id_x    = 1'b1;
            fcnt_d  = fcnt_q - FCNT_W'(1);
            state_d = (fcnt_q <= FCNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (load_use) begin
            ex_x    = 1'b1;
            state_d = ST_RUN;
        end else begin
            if_ena  = 1'b1;
            id_ena  = 1'b1;
            state_d = ST_RUN;
        end
    end

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.clr_cnt) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!if_ena && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (accept && (flush_q != '1)) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    // State, flush countdown, pending redirect and counter registers.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.if_ena       = if_ena;
    assign bus.id_ena       = id_ena;
    assign bus.id_x         = id_x;
    assign bus.ex_x         = ex_x;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 8;
    localparam longint unsigned CMAX = (64'd1 << CW) - 1;

    logic stg_clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .stg_clk (stg_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 stg_clk = ~stg_clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining bubble cycles, waiting-on-memory flag,
    // deferred redirect, and the two counter values.
    int unsigned     m_left  = 0;
    bit              m_wait  = 0;
    bit              m_pend  = 0;
    longint unsigned m_stall = 0;
    longint unsigned m_flush = 0;

    always @(negedge stg_clk) begin
        bit lu, mp, acc;
        bit e_if, e_id, e_idx, e_exx;
        if (reset) begin
            chk("rst_if_ena", bus.if_ena, 0);
            chk("rst_id_ena", bus.id_ena, 0);
            chk("rst_id_x",   bus.id_x,   1);
            chk("rst_ex_x",   bus.ex_x,   1);
            chk("rst_stall",  bus.stall_cycles, 0);
            chk("rst_flush",  bus.flush_events, 0);
            m_left = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        end else begin
            lu = bus.ex_rd_memory && bus.ex_save_to_reg && (bus.ex_rd != 0) &&
                 ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
                  (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
            mp  = bus.ex_mispredict || m_pend;
            acc = 0;
            {e_if, e_id, e_idx, e_exx} = 4'b0000;
            if (m_wait && bus.mem_busy) begin
                if (bus.ex_mispredict) m_pend = 1;
            end else if (mp) begin
                {e_if, e_id, e_idx, e_exx} = 4'b1111;
                acc = 1; m_pend = 0; m_wait = 0; m_left = FC;
            end else if (bus.mem_busy) begin
                m_wait = 1;
            end else if (m_left > 0) begin
                {e_if, e_id, e_idx, e_exx} = 4'b1110;
                m_left--; m_wait = 0;
            end else if (lu) begin
                e_exx = 1; m_wait = 0;
            end else begin
                {e_if, e_id} = 2'b11; m_wait = 0;
            end
            chk("if_ena", bus.if_ena, e_if);
            chk("id_ena", bus.id_ena, e_id);
            chk("id_x",   bus.id_x,   e_idx);
            chk("ex_x",   bus.ex_x,   e_exx);
            chk("stall_cycles", bus.stall_cycles, m_stall);
            chk("flush_events", bus.flush_events, m_flush);
            if (bus.clr_cnt) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_if && m_stall < CMAX) m_stall++;
                if (acc && m_flush < CMAX) m_flush++;
            end
        end
    end

    task automatic nxt();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.ex_rd = '0; bus.ex_rd_memory = 0; bus.ex_save_to_reg = 0;
        bus.ex_mispredict = 0; bus.mem_busy = 0; bus.clr_cnt = 0;
    endtask

    task automatic clear_counters();
        idle();
        bus.clr_cnt = 1;
        nxt();
        bus.clr_cnt = 0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
        bus.ex_rd = rd; bus.ex_rd_memory = 1; bus.ex_save_to_reg = 1;
        bus.id_rs1 = rs1; bus.id_rs1_used = 1;
    endtask

    initial begin
        reset = 1;
        idle();
        nxt(); nxt();
        #2;
        chk("lit_rst_id_x", bus.id_x, 1);
        chk("lit_rst_if_ena", bus.if_ena, 0);
        nxt();
        reset = 0;
        #2;
        chk("lit_first_run_if_ena", bus.if_ena, 1);
        nxt();

        // Load-use stall, and the x0 exemption
        clear_counters();
        set_load(5'd5, 5'd5);
        #2;
        chk("lit_lu_id_ena", bus.id_ena, 0);
        chk("lit_lu_ex_x",   bus.ex_x,   1);
        nxt();
        idle();
        #2;
        chk("lit_lu_after_id_ena", bus.id_ena, 1);
        chk("lit_lu_stall", bus.stall_cycles, 1);
        set_load(5'd0, 5'd0);
        #2;
        chk("lit_x0_id_ena", bus.id_ena, 1);
        chk("lit_x0_ex_x",   bus.ex_x,   0);
        nxt();
        idle();
        chk("lit_x0_stall", bus.stall_cycles, 1);

        // Mispredict: three bubble cycles, squash of execute only on the first
        clear_counters();
        bus.ex_mispredict = 1;
        #2;
        chk("lit_mp_id_x", bus.id_x, 1);
        chk("lit_mp_ex_x", bus.ex_x, 1);
        nxt();
        bus.ex_mispredict = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("lit_fl_id_x", bus.id_x, 1);
            chk("lit_fl_ex_x", bus.ex_x, 0);
            nxt();
        end
        #2;
        chk("lit_fl_done_id_x", bus.id_x, 0);
        chk("lit_fl_events", bus.flush_events, 1);

        // Memory wait entered with flush count 1
        clear_counters();
        bus.ex_mispredict = 1;
        nxt();
        bus.ex_mispredict = 0;
        nxt();
        bus.mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("lit_mw_if_ena", bus.if_ena, 0);
            chk("lit_mw_id_x",   bus.id_x,   0);
            nxt();
        end
        bus.mem_busy = 0;
        #2;
        chk("lit_mw_resume_id_x", bus.id_x, 1);
        nxt();
        #2;
        chk("lit_mw_end_id_x", bus.id_x, 0);
        chk("lit_mw_stall", bus.stall_cycles, 4);

        // Redirect arriving during a memory wait is deferred
        clear_counters();
        bus.mem_busy = 1;
        nxt();
        bus.ex_mispredict = 1;
        #2;
        chk("lit_pend_id_x", bus.id_x, 0);
        nxt();
        bus.ex_mispredict = 0;
        nxt();
        bus.mem_busy = 0;
        #2;
        chk("lit_pend_id_x_go", bus.id_x, 1);
        chk("lit_pend_ex_x_go", bus.ex_x, 1);
        nxt();
        chk("lit_pend_events", bus.flush_events, 1);
        nxt(); nxt();

        // Load-use together with mispredict: flush wins, no stall
        clear_counters();
        set_load(5'd7, 5'd7);
        bus.ex_mispredict = 1;
        #2;
        chk("lit_both_if_ena", bus.if_ena, 1);
        chk("lit_both_ex_x",   bus.ex_x,   1);
        nxt();
        idle();
        nxt(); nxt();
        chk("lit_both_stall", bus.stall_cycles, 0);
        chk("lit_both_flush", bus.flush_events, 1);

        // Reset while waiting with a deferred redirect
        bus.mem_busy = 1;
        nxt();
        bus.ex_mispredict = 1;
        nxt();
        reset = 1;
        #2;
        chk("lit_rmw_stall", bus.stall_cycles, 0);
        chk("lit_rmw_id_x",  bus.id_x, 1);
        nxt();
        reset = 0;
        idle();
        #2;
        chk("lit_rmw_run_if", bus.if_ena, 1);
        chk("lit_rmw_run_idx", bus.id_x, 0);
        nxt();
        chk("lit_rmw_flush", bus.flush_events, 0);

        // Random traffic; long enough to drive the counters into saturation
        for (int unsigned n = 0; n < 4000; n++) begin
            bus.id_rs1         = 5'($urandom_range(0, 3));
            bus.id_rs2         = 5'($urandom_range(0, 3));
            bus.ex_rd          = 5'($urandom_range(0, 3));
            bus.id_rs1_used    = 1'($urandom);
            bus.id_rs2_used    = 1'($urandom);
            bus.ex_rd_memory   = ($urandom_range(0, 2) != 0);
            bus.ex_save_to_reg = ($urandom_range(0, 3) != 0);
            bus.ex_mispredict  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) bus.mem_busy = ~bus.mem_busy;
            bus.clr_cnt        = ($urandom_range(0, 1499) == 0);
            reset              = ($urandom_range(0, 1499) == 0);
            nxt();
        end
        reset = 0;
        idle();
        nxt(); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
